can_tx_sched: RTL and testbench

Transmit scheduler for the CAN controller. It arbitrates among NUM_MB host-armed transmit mailboxes by CAN identifier priority: the lowest ID wins, as on the bus. It hands the winning mailbox to the CAN protocol engine through a start/ack/done handshake and handles arbitration-loss requeue, bounded error retry and host abort. It sits between the host register file and the protocol engine inside tt_um_noritsuna_CAN_CTRL.

---
 rtl/can_tx_sched.sv | 142 ++++++++++++++
 tb/tb_can_tx_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_sched.sv
// Transmit scheduler: picks the lowest-ID pending mailbox, hands it to the
// protocol engine via start/ack/done, and handles requeue, retry and abort.
module can_tx_sched #(
   parameter int NUM_MB    = 4,
   parameter int ID_W      = 11,
   parameter int MAX_RETRY = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_MB-1:0]          mb_set,
   input  logic [NUM_MB-1:0]          mb_abort,
   input  logic [NUM_MB*ID_W-1:0]     mb_id,
   input  logic                       bus_idle,
   input  logic                       tx_ack,
   input  logic                       tx_done,
   input  logic [1:0]                 tx_status,
   output logic                       tx_start,
   output logic [$clog2(NUM_MB)-1:0]  tx_sel,
   output logic [ID_W-1:0]            tx_id,
   output logic [NUM_MB-1:0]          mb_pending,
   output logic [NUM_MB-1:0]          mb_done,
   output logic [NUM_MB-1:0]          mb_fail,
   output logic                       busy
);

   localparam int SEL_W = $clog2(NUM_MB);
   localparam int CNT_W = $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {S_IDLE, S_SELECT, S_REQ, S_BUSY} state_t;

   state_t              state, state_nx;
   logic [NUM_MB-1:0]   pending;
   logic [NUM_MB-1:0]   abort_req;
   logic [CNT_W-1:0]    err_cnt [NUM_MB];
   logic [NUM_MB-1:0]   cand;
   logic                win_found;
   logic [SEL_W-1:0]    win_sel;
   logic [ID_W-1:0]     win_id;

   // Mailboxes being aborted this cycle are excluded so SELECT never latches one.
   always_comb begin
      cand      = pending & ~mb_abort;
      win_found = 1'b0;
      win_sel   = '0;
      win_id    = '0;
      for (int i = 0; i < NUM_MB; i++) begin
         if (cand[i] && (!win_found || (mb_id[i*ID_W +: ID_W] < win_id))) begin
            win_found = 1'b1;
            win_sel   = SEL_W'(i);
            win_id    = mb_id[i*ID_W +: ID_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if ((|pending) && bus_idle) state_nx = S_SELECT;
         S_SELECT: state_nx = win_found ? S_REQ : S_IDLE;
         S_REQ: begin
            if (tx_ack)                state_nx = S_BUSY;
            else if (mb_abort[tx_sel]) state_nx = S_IDLE;
         end
         S_BUSY:   if (tx_done) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sel <= '0;
         tx_id  <= '0;
      end else if (state == S_SELECT && win_found) begin
         tx_sel <= win_sel;
         tx_id  <= win_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= '0;
         abort_req <= '0;
         mb_done   <= '0;
         mb_fail   <= '0;
         for (int i = 0; i < NUM_MB; i++) err_cnt[i] <= '0;
      end else begin
         mb_done <= '0;
         mb_fail <= '0;
         for (int i = 0; i < NUM_MB; i++) begin
            if (state == S_REQ && tx_sel == SEL_W'(i)) begin
               if (mb_abort[i]) begin
                  if (tx_ack) begin
                     abort_req[i] <= 1'b1;
                  end else begin
                     pending[i] <= 1'b0;
                     mb_fail[i] <= 1'b1;
                  end
               end
            end else if (state == S_BUSY && tx_sel == SEL_W'(i)) begin
               if (tx_done) begin
                  abort_req[i] <= 1'b0;
                  if (tx_status == 2'b00) begin
                     pending[i] <= 1'b0;
                     mb_done[i] <= 1'b1;
                  end else if (abort_req[i] || mb_abort[i]) begin
                     pending[i] <= 1'b0;
                     mb_fail[i] <= 1'b1;
                  end else if (tx_status[1]) begin
                     // 10 and 11 both count as errors; 01 just requeues.
                     err_cnt[i] <= err_cnt[i] + 1'b1;
                     if (err_cnt[i] == CNT_W'(MAX_RETRY - 1)) begin
                        pending[i] <= 1'b0;
                        mb_fail[i] <= 1'b1;
                     end
                  end
               end else if (mb_abort[i]) begin
                  abort_req[i] <= 1'b1;
               end
            end else if (mb_abort[i]) begin
               if (pending[i]) begin
                  pending[i] <= 1'b0;
                  mb_fail[i] <= 1'b1;
               end
            end else if (mb_set[i] && !pending[i]) begin
               pending[i]   <= 1'b1;
               abort_req[i] <= 1'b0;
               err_cnt[i]   <= '0;
            end
         end
      end
   end

   assign tx_start   = (state == S_REQ);
   assign busy       = (state != S_IDLE);
   assign mb_pending = pending;

endmodule

// File: tb/tb_can_tx_sched.sv
// Directed bench for can_tx_sched: stimulus pushes expected engine requests
// and done/fail pulses into a queue; a negedge monitor pops and compares.
module tb_can_tx_sched;

   localparam int NUM_MB = 4;
   localparam int ID_W   = 11;
   localparam int EW     = 2 + 8 + ID_W;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [NUM_MB-1:0]      mb_set = '0;
   logic [NUM_MB-1:0]      mb_abort = '0;
   logic [NUM_MB*ID_W-1:0] mb_id = '0;
   logic                   bus_idle = 1'b1;
   logic                   tx_ack = 1'b0;
   logic                   tx_done = 1'b0;
   logic [1:0]             tx_status = 2'b00;
   logic                   tx_start;
   logic [1:0]             tx_sel;
   logic [ID_W-1:0]        tx_id;
   logic [NUM_MB-1:0]      mb_pending, mb_done, mb_fail;
   logic                   busy;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int start_base;
   logic prev_start = 1'b0;
   logic [EW-1:0] exp_q[$];

   can_tx_sched #(.NUM_MB(NUM_MB), .ID_W(ID_W), .MAX_RETRY(3)) dut (
      .clk(clk), .rst_n(rst_n), .mb_set(mb_set), .mb_abort(mb_abort),
      .mb_id(mb_id), .bus_idle(bus_idle), .tx_ack(tx_ack), .tx_done(tx_done),
      .tx_status(tx_status), .tx_start(tx_start), .tx_sel(tx_sel),
      .tx_id(tx_id), .mb_pending(mb_pending), .mb_done(mb_done),
      .mb_fail(mb_fail), .busy(busy)
   );

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [EW-1:0] ev(input logic [1:0] k, input logic [7:0] v,
                                        input logic [ID_W-1:0] id);
      return {k, v, id};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sb_compare(input string name, input logic [EW-1:0] obs);
      logic [EW-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: unexpected event 0x%0h", name, obs);
      end else begin
         e = exp_q.pop_front();
         if (obs !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, e);
         end
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (tx_start && !prev_start) begin
            start_cnt++;
            sb_compare("start", ev(2'd0, 8'(tx_sel), tx_id));
         end
         if (mb_done != '0) sb_compare("done", ev(2'd1, 8'(mb_done), '0));
         if (mb_fail != '0) sb_compare("fail", ev(2'd2, 8'(mb_fail), '0));
      end
      prev_start = tx_start;
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input int idx, input logic [ID_W-1:0] id);
      mb_id[idx*ID_W +: ID_W] = id;
   endtask

   task automatic arm(input logic [NUM_MB-1:0] m);
      step();
      mb_set = m;
      step();
      mb_set = '0;
   endtask

   task automatic abort(input logic [NUM_MB-1:0] m);
      mb_abort = m;
      step();
      mb_abort = '0;
   endtask

   task automatic wait_start();
      int n = 0;
      while (!tx_start && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (!tx_start) begin
         errors++;
         $display("FAIL wait_start: tx_start 0 after %0d cycles, required 1", n);
      end
   endtask

   task automatic ack_frame();
      wait_start();
      tx_ack = 1'b1;
      step();
      tx_ack = 1'b0;
   endtask

   task automatic finish(input logic [1:0] st);
      step();
      tx_done   = 1'b1;
      tx_status = st;
      step();
      tx_done   = 1'b0;
      tx_status = 2'b00;
   endtask

   initial begin
      // reset state
      repeat (3) step();
      check("rst_tx_start", tx_start, 0);
      check("rst_busy", busy, 0);
      check("rst_pending", mb_pending, 0);
      check("rst_tx_id", tx_id, 0);
      rst_n = 1'b1;
      repeat (2) step();

      // single frame with latency check
      set_id(1, 11'h123);
      exp_q.push_back(ev(2'd0, 8'd1, 11'h123));
      exp_q.push_back(ev(2'd1, 8'h02, '0));
      arm(4'b0010);
      check("single_pending", mb_pending, 4'b0010);
      check("single_start_k", tx_start, 0);
      step();
      check("single_start_k1", tx_start, 0);
      check("single_busy", busy, 1);
      step();
      check("single_start_k2", tx_start, 1);
      check("single_sel", tx_sel, 1);
      check("single_id", tx_id, 11'h123);
      tx_ack = 1'b1;
      step();
      tx_ack = 1'b0;
      check("single_start_drop", tx_start, 0);
      finish(2'b00);
      check("single_done", mb_done, 4'b0010);
      check("single_pending_clr", mb_pending, 0);
      check("single_idle", busy, 0);

      // priority: lowest id, ties to lowest index
      set_id(0, 11'h300); set_id(2, 11'h100); set_id(3, 11'h100);
      exp_q.push_back(ev(2'd0, 8'd2, 11'h100)); exp_q.push_back(ev(2'd1, 8'h04, '0));
      exp_q.push_back(ev(2'd0, 8'd3, 11'h100)); exp_q.push_back(ev(2'd1, 8'h08, '0));
      exp_q.push_back(ev(2'd0, 8'd0, 11'h300)); exp_q.push_back(ev(2'd1, 8'h01, '0));
      arm(4'b1101);
      for (int i = 0; i < 3; i++) begin
         ack_frame();
         finish(2'b00);
      end
      check("prio_pending", mb_pending, 0);

      // arbitration loss requeue; two later errors must not exhaust retries
      set_id(0, 11'h200); set_id(1, 11'h050);
      exp_q.push_back(ev(2'd0, 8'd0, 11'h200));
      exp_q.push_back(ev(2'd0, 8'd1, 11'h050)); exp_q.push_back(ev(2'd1, 8'h02, '0));
      for (int i = 0; i < 3; i++) exp_q.push_back(ev(2'd0, 8'd0, 11'h200));
      exp_q.push_back(ev(2'd1, 8'h01, '0));
      arm(4'b0001);
      ack_frame();
      arm(4'b0010);
      finish(2'b01);
      check("arb_requeue", mb_pending, 4'b0011);
      ack_frame(); finish(2'b00);
      ack_frame(); finish(2'b10);
      ack_frame(); finish(2'b11);
      ack_frame(); finish(2'b00);
      check("arb_final_pending", mb_pending, 0);

      // retry limit
      set_id(2, 11'h010);
      start_base = start_cnt;
      for (int i = 0; i < 3; i++) exp_q.push_back(ev(2'd0, 8'd2, 11'h010));
      exp_q.push_back(ev(2'd2, 8'h04, '0));
      arm(4'b0100);
      for (int i = 0; i < 3; i++) begin
         ack_frame();
         finish(2'b10);
      end
      check("retry_fail", mb_fail, 4'b0100);
      repeat (5) step();
      check("retry_starts", start_cnt - start_base, 3);
      check("retry_pending", mb_pending, 0);

      // abort in REQ before ack
      set_id(3, 11'h0AA);
      exp_q.push_back(ev(2'd0, 8'd3, 11'h0AA)); exp_q.push_back(ev(2'd2, 8'h08, '0));
      arm(4'b1000);
      wait_start();
      abort(4'b1000);
      check("req_abort_start", tx_start, 0);
      check("req_abort_fail", mb_fail, 4'b1000);
      check("req_abort_pending", mb_pending, 0);

      // abort in BUSY then error: fail, no retry
      set_id(1, 11'h111);
      exp_q.push_back(ev(2'd0, 8'd1, 11'h111)); exp_q.push_back(ev(2'd2, 8'h02, '0));
      arm(4'b0010);
      ack_frame();
      abort(4'b0010);
      check("busy_abort_hold", mb_pending, 4'b0010);
      finish(2'b10);
      repeat (6) step();
      check("busy_abort_err_pending", mb_pending, 0);

      // abort in BUSY then success: done
      exp_q.push_back(ev(2'd0, 8'd1, 11'h111)); exp_q.push_back(ev(2'd1, 8'h02, '0));
      arm(4'b0010);
      ack_frame();
      abort(4'b0010);
      finish(2'b00);
      check("busy_abort_ok_pending", mb_pending, 0);

      // abort of idle-pending mailbox, abort of non-pending, bus_idle gating
      bus_idle = 1'b0;
      set_id(0, 11'h0F0); set_id(2, 11'h0E0);
      arm(4'b0101);
      exp_q.push_back(ev(2'd2, 8'h01, '0));
      abort(4'b0001);
      check("idle_abort_fail", mb_fail, 4'b0001);
      check("idle_abort_pending", mb_pending, 4'b0100);
      abort(4'b1000);
      check("nonpending_abort", mb_pending, 4'b0100);
      check("bus_idle_gate", busy, 0);
      exp_q.push_back(ev(2'd0, 8'd2, 11'h0E0)); exp_q.push_back(ev(2'd1, 8'h04, '0));
      bus_idle = 1'b1;
      ack_frame();
      finish(2'b00);

      // reset during BUSY with three mailboxes pending
      set_id(0, 11'h010); set_id(1, 11'h020); set_id(2, 11'h030);
      exp_q.push_back(ev(2'd0, 8'd0, 11'h010));
      arm(4'b0111);
      ack_frame();
      step();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_pending", mb_pending, 0);
      check("mid_rst_id", tx_id, 0);
      check("mid_rst_start", tx_start, 0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (10) step();
      check("post_rst_pending", mb_pending, 0);
      check("post_rst_busy", busy, 0);

      repeat (3) step();
      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
